// File: rtl/mux4_scan_ctrl_pkg.sv
// Shared definitions for the mux4 scan sequencer: FSM state encoding,
// channel geometry and the "next enabled channel" search used when the
// channel-skip build option (MUX_SCAN_SKIP_EN) is enabled.
package mux4_scan_ctrl_pkg;

  localparam int SEL_W = 2;
  localparam int NCH   = 4;
  localparam logic [SEL_W-1:0] SEL_LAST = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } scan_state_e;

  // Result of a channel search: found=0 means no enabled channel remains.
  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } chan_pick_t;

  // Lowest enabled channel with index >= lo. Walking downwards lets the
  // last hit (the lowest index) win without a break statement.
  function automatic chan_pick_t next_chan(input logic [NCH-1:0] en, input int lo);
    chan_pick_t p;
    p = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (i >= lo && en[i]) begin
        p.found = 1'b1;
        p.idx   = i[SEL_W-1:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/mux4_scan_ctrl_if.sv
// Bus between the control logic / mux4_1 and the scan sequencer.
// slave  : the sequencer side (mux4_scan_ctrl)
// master : the environment side (control logic plus the mux output)
interface mux4_scan_ctrl_if;
  import mux4_scan_ctrl_pkg::*;

  logic           start;
  logic           stop;
  logic [NCH-1:0] chan_en;
  logic           mux_y;
  logic           s0;
  logic           s1;
  logic [NCH-1:0] sample_data;
  logic           sample_valid;
  logic           busy;

  modport master (
    output start, stop, chan_en, mux_y,
    input  s0, s1, sample_data, sample_valid, busy
  );

  modport slave (
    input  start, stop, chan_en, mux_y,
    output s0, s1, sample_data, sample_valid, busy
  );

endinterface

// File: rtl/scan_dwell_cnt.sv
// Settle down-counter for the scan sequencer. load has priority over dec;
// the count saturates at zero, and zero flags the end of the dwell.
module scan_dwell_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: reload wins, otherwise decrement while non-zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mux4_scan_ctrl.sv
// mux4_scan_ctrl: steps the mux4_1 selects through channels 0..3, holds
// each select SETTLE_CYC cycles, samples mux_y once per channel and
// publishes the 4 sampled bits with a one-cycle valid pulse.
// Build option MUX_SCAN_SKIP_EN: channels with chan_en[i]=0 (captured at
// start) are skipped at zero cycle cost and read back as 0.
module mux4_scan_ctrl
  import mux4_scan_ctrl_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 4
) (
  input logic               clk,
  input logic               rst,
  mux4_scan_ctrl_if.slave   bus
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYC - 1);

  scan_state_e      state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [NCH-1:0]   shadow_q, shadow_d;
  logic [NCH-1:0]   data_q, data_d;
  logic [NCH-1:0]   en_q, en_d;
  logic [NCH-1:0]   en_start;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic             start_ok;
  chan_pick_t       first_pick, next_pick;

`ifdef MUX_SCAN_SKIP_EN
  assign en_start = bus.chan_en;
`else
  // All channels are always scanned; chan_en is deliberately ignored.
  logic chan_en_unused;
  assign chan_en_unused = ^bus.chan_en;
  assign en_start       = '1;
`endif

  // stop outranks start in IDLE and DONE.
  assign start_ok   = bus.start & ~bus.stop;
  assign first_pick = next_chan(en_start, 0);
  assign next_pick  = next_chan(en_q, int'(sel_q) + 1);

  scan_dwell_cnt #(.CNT_W(CNT_W)) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (RELOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Select, shadow, published data and captured enable mask.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q    <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      en_q     <= '0;
    end else begin
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      en_q     <= en_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    en_d     = en_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        sel_d   = '0;
        if (start_ok) begin
          en_d     = en_start;
          shadow_d = '0;
          cnt_load = 1'b1;
          if (first_pick.found) begin
            sel_d   = first_pick.idx;
            state_d = ST_SETTLE;
          end else begin
            // Nothing enabled: one pass through SAMPLE on the last channel
            // (its enable is 0, so nothing is captured) leads to DONE.
            sel_d   = SEL_LAST;
            state_d = ST_SAMPLE;
          end
        end
      end
      ST_SETTLE: begin
        if (bus.stop) begin
          state_d  = ST_IDLE;
          sel_d    = '0;
          shadow_d = '0;
        end else if (cnt_zero) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (bus.stop) begin
          state_d  = ST_IDLE;
          sel_d    = '0;
          shadow_d = '0;
        end else begin
          shadow_d[sel_q] = bus.mux_y & en_q[sel_q];
          if (next_pick.found) begin
            sel_d    = next_pick.idx;
            cnt_load = 1'b1;
            state_d  = ST_SETTLE;
          end else begin
            // Publish including the bit captured this cycle.
            data_d  = shadow_d;
            state_d = ST_DONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode; selects and data come straight from registers.
  always_comb begin
    bus.s0           = sel_q[0];
    bus.s1           = sel_q[1];
    bus.sample_data  = data_q;
    bus.sample_valid = (state_q == ST_DONE);
    bus.busy         = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  end

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Randomized bench for mux4_scan_ctrl. The reference model is a timeline:
// every enabled channel occupies SETTLE_CYC+1 cycles with its select on the
// mux, the bit seen on its last cycle is what gets captured, and one valid
// cycle follows the last channel. Honors MUX_SCAN_SKIP_EN when defined.
module tb_mux4_scan_ctrl;

  localparam int S = 2;

`ifdef MUX_SCAN_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] din;       // {d,c,b,a}
  logic [3:0] exp_data;
  int         n_vec = 0;
  int         n_err = 0;

  mux4_scan_ctrl_if bus ();

  // mux4_1 behaviour: y follows the selected input combinationally.
  assign bus.mux_y = din[{bus.s1, bus.s0}];

  mux4_scan_ctrl #(.SETTLE_CYC(S), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".sel"},   8'({bus.s1, bus.s0}), 8'd0);
    chk({tag, ".busy"},  8'(bus.busy), 8'd0);
    chk({tag, ".valid"}, 8'(bus.sample_valid), 8'd0);
    chk({tag, ".data"},  8'(bus.sample_data), 8'(exp_data));
  endtask

  // nscans back-to-back scans. stop_cyc >= 0 aborts the final scan at that
  // cycle index (counted from the first cycle after start). end_stop raises
  // start and stop together in the final valid cycle.
  task automatic run_scans(input int nscans, input logic [3:0] en_req, input int stop_cyc,
                           input bit end_stop, input bit hold_din, input logic [3:0] din_val);
    logic [3:0] en_eff;
    logic [3:0] shadow;
    int         cyc;
    en_eff = SKIP ? en_req : 4'hF;
    check_idle("pre");
    if (hold_din) din = din_val;
    bus.chan_en = en_req;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int s = 0; s < nscans; s++) begin
      shadow = '0;
      cyc    = 0;
      if (en_eff == 4'd0) begin
        chk("zero.valid", 8'(bus.sample_valid), 8'd0);
        tick();
      end else begin
        for (int ch = 0; ch < 4; ch++) begin
          if (en_eff[ch]) begin
            for (int k = 0; k <= S; k++) begin
              chk("scan.sel",   8'({bus.s1, bus.s0}), 8'(ch));
              chk("scan.busy",  8'(bus.busy), 8'd1);
              chk("scan.valid", 8'(bus.sample_valid), 8'd0);
              chk("scan.hold",  8'(bus.sample_data), 8'(exp_data));
              if (!hold_din) din = 4'($urandom);
              if (k == S) shadow[ch] = din[ch];
              if (s == nscans - 1 && cyc == stop_cyc) begin
                bus.stop = 1'b1;
                tick();
                bus.stop = 1'b0;
                check_idle("stop");
                tick();
                check_idle("stop2");
                $display("scan aborted by stop at cycle %0d, data kept %b", cyc, exp_data);
                return;
              end
              cyc++;
              tick();
            end
          end
        end
      end
      exp_data = shadow;
      chk("done.valid", 8'(bus.sample_valid), 8'd1);
      chk("done.busy",  8'(bus.busy), 8'd0);
      chk("done.data",  8'(bus.sample_data), 8'(exp_data));
      $display("scan %0d en=%b data=%b expected=%b", s, en_eff, bus.sample_data, exp_data);
      if (s < nscans - 1) begin
        bus.start = 1'b1;
      end else if (end_stop) begin
        bus.start = 1'b1;
        bus.stop  = 1'b1;
      end
      tick();
      bus.start = 1'b0;
      bus.stop  = 1'b0;
    end
    check_idle("post");
  endtask

  initial begin
    logic [3:0] en_r;
    int         n_r, len_r, stop_r, pop_r;
    bit         es_r;

    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.chan_en = 4'h0;
    din         = 4'h0;
    exp_data    = 4'h0;
    repeat (3) tick();
    rst = 1'b0;
    check_idle("reset");

    // a=1,b=0,c=1,d=1 -> 4'b1101
    run_scans(1, 4'hF, -1, 1'b0, 1'b1, 4'b1101);
    // three back-to-back scans with changing data
    run_scans(3, 4'hF, -1, 1'b0, 1'b0, 4'h0);
    // stop during channel 2 SAMPLE
    run_scans(1, 4'hF, 2 * (S + 1) + S, 1'b0, 1'b0, 4'h0);
    // start and stop together in IDLE: stop wins
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check_idle("idle_ss");

`ifdef MUX_SCAN_SKIP_EN
    run_scans(1, 4'b1010, -1, 1'b0, 1'b1, 4'hF);
    run_scans(1, 4'b0000, -1, 1'b0, 1'b1, 4'hF);
`else
    run_scans(1, 4'b0000, -1, 1'b0, 1'b1, 4'hF);
`endif

    for (int it = 0; it < 25; it++) begin
      n_r   = int'($urandom_range(1, 3));
      en_r  = 4'($urandom);
      pop_r = 0;
      for (int i = 0; i < 4; i++) if (SKIP ? en_r[i] : 1'b1) pop_r++;
      len_r  = pop_r * (S + 1);
      stop_r = -1;
      if (len_r > 0 && $urandom_range(0, 3) == 0) stop_r = int'($urandom_range(0, len_r - 1));
      es_r = ($urandom_range(0, 3) == 0);
      run_scans(n_r, en_r, stop_r, es_r, 1'b0, 4'h0);
    end

    // known non-zero data, then reset for 2 cycles mid-scan
    run_scans(1, 4'hF, -1, 1'b0, 1'b1, 4'b1101);
    bus.chan_en = 4'hF;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst      = 1'b0;
    exp_data = 4'h0;
    check_idle("rst_mid");
    tick();
    check_idle("rst_mid2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
